chunked_serial_subtractor: RTL and testbench
============================================

Name: chunked_serial_subtractor

Overview:
- Multi-cycle, parametrised N-bit subtractor. Computes d = a - b - bin one CHUNK-bit slice per clock, LSB slice first.
- Each slice uses a ripple full-subtractor chain. The borrow is registered between slices.
- Start/done handshake; adds signed-overflow and zero flags.
- Used where a full-width ripple borrow chain would miss timing, or where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- CHUNK, 4, bits processed per clock; must divide WIDTH (1 = bit-serial, WIDTH = single-cycle).
- NCH (localparam), WIDTH/CHUNK, number of slice cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising edge while not busy
- a  input  WIDTH  minuend; sampled with start
- b  input  WIDTH  subtrahend; sampled with start
- bin  input  1  borrow-in; sampled with start
- busy  output  1  high while slices are being computed
- done  output  1  one-cycle pulse; result registers updated
- d  output  WIDTH  difference, registered
- bout  output  1  borrow-out of MSB slice (1 = unsigned a < b + bin)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  d == 0

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, d, bout, ovf, zero all 0. Slice counter, work registers and borrow register cleared. Takes effect immediately, including mid-operation; the in-flight operation is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - Latch a, b, bin into work registers; borrow_reg=bin; cnt=0; go to RUN.
  - busy=1 from E0.
- RUN, edge Ek (k=1..NCH):
  - Slice k-1 = bits [(k-1)*CHUNK +: CHUNK] of latched a and b.
  - Computed combinationally with a CHUNK-bit full-subtractor ripple chain. Per bit: diff = a^b^bi; bo = (~a&b) | (~(a^b)&bi). Borrow-in is borrow_reg.
  - Slice diff is written to the work result; borrow_reg takes the slice borrow-out; cnt increments.
  - At E_NCH:
    - d takes the full work result.
    - bout takes the final borrow.
    - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]), using latched a/b and new d.
    - zero = (new d == 0).
    - State goes to DONE; busy=0; done=1.
- DONE: lasts exactly one cycle.
  - done=1, busy=0.
  - At the next edge, done goes to 0.
  - If start=1 at that edge, a new operation is accepted exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start at E0 gives done high in the cycle following E_NCH (NCH edges after E0). Throughput is one result per NCH+1 cycles.
- start while busy (RUN) is ignored. Operands are not re-sampled and the operation is unaffected.
- d, bout, ovf and zero change only at E_NCH (or reset). They hold the last result through IDLE and during the next RUN.
- Results are modulo 2^WIDTH; no saturation.
  - a=0, b=2^WIDTH-1, bin=1 gives d=0, bout=1 (wrap).
- CHUNK=WIDTH: NCH=1, one RUN cycle. CHUNK=1: bit-serial, WIDTH RUN cycles.
- ovf also accounts for bin: it is derived from result sign, so a=MIN, b=0, bin=1 sets ovf=1.

Test Plan:
- WIDTH=16, CHUNK=4; a=0x000F, b=0x0001, bin=0, start pulse at E0 -> busy for E0..E3; at E4 d=0x000E, bout=0, ovf=0, zero=0; done high for exactly one cycle after E4.
- a=0x0100, b=0x0001, bin=0 (cross-slice borrow) -> d=0x00FF, bout=0. Also a=0x0002, b=0x0008, bin=1 -> d=0xFFF9, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 -> d=0x7FFF, ovf=1, bout=0. Then a=0x1234, b=0x1234, bin=0 -> d=0x0000, zero=1.
- start re-asserted with different operands during RUN -> ignored, original result produced. start held high through DONE -> second operation begins back-to-back; two done pulses 5 cycles apart.
- rst asserted asynchronously between E2 and E3 -> busy, done, d, bout, ovf, zero all 0 immediately; no done pulse follows; next start operates normally.
- Re-run the first scenario and a random-vector sweep with CHUNK=1 (16 RUN cycles) and CHUNK=16 (1 RUN cycle) -> results match (a - b - bin) mod 2^16 and the reference bout/ovf.

Source files
------------

// File: rtl/chunked_serial_subtractor.sv
// Purpose: d = a - b - bin computed CHUNK bits per clock, LSB slice first, with a registered inter-slice borrow.
// Latency: start sampled at E0 -> done pulses in the cycle after E0+NCH; one result per NCH+1 cycles.
// Backpressure: none; start is ignored while busy, and the result holds until the next completion.
module chunked_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] diff_sl;
    logic             bo_sl;
    logic [WIDTH-1:0] res_upd;
    logic             last_slice;
    logic             accept;

    assign last_slice = (cnt_q == CW'(NCH - 1));
    // A new operation may start from IDLE or directly out of DONE (back-to-back).
    assign accept     = start && (state_q != RUN);

    // Pick the operand slice addressed by the slice counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Ripple full-subtractor chain across one slice, fed by the registered borrow.
    always_comb begin
        logic br;
        br      = brw_q;
        diff_sl = '0;
        for (int j = 0; j < CHUNK; j++) begin
            diff_sl[j] = a_sl[j] ^ b_sl[j] ^ br;
            br         = (~a_sl[j] & b_sl[j]) | (~(a_sl[j] ^ b_sl[j]) & br);
        end
        bo_sl = br;
    end

    // Merge the freshly computed slice into the work result.
    always_comb begin
        res_upd = res_q;
        for (int i = 0; i < NCH; i++) begin
            if (cnt_q == CW'(i)) begin
                res_upd[i*CHUNK +: CHUNK] = diff_sl;
            end
        end
    end

    // Next-state logic: IDLE/DONE accept start, RUN walks NCH slices then reports.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: latch operands on accept, step slices in RUN, publish at the last slice.
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        brw_d  = brw_q;
        d_d    = d_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            brw_d = bin;
            cnt_d = '0;
            res_d = '0;
        end else if (state_q == RUN) begin
            res_d = res_upd;
            brw_d = bo_sl;
            cnt_d = cnt_q + CW'(1);
            if (last_slice) begin
                cnt_d  = '0;
                d_d    = res_upd;
                bout_d = bo_sl;
                // Sign-based overflow: naturally covers the borrow-in contribution.
                ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_upd[WIDTH-1] != a_q[WIDTH-1]);
                zero_d = (res_upd == '0);
            end
        end
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Work and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            brw_q  <= 1'b0;
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            brw_q  <= brw_d;
            d_q    <= d_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_chunked_serial_subtractor.sv
// Purpose: scoreboard bench for chunked_serial_subtractor at CHUNK=4, 1 and 16.
// Latency: checks done timing against NCH+1 cycles and back-to-back spacing.
// Backpressure: exercises start-while-busy, start held through DONE and async reset mid-run.
module tb_chunked_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start1, start16;
    logic [15:0] a, b;
    logic        bin;

    logic        busy4, done4, bout4, ovf4, zero4;
    logic [15:0] d4;
    logic        busy1, done1, bout1, ovf1, zero1;
    logic [15:0] d1;
    logic        busy16, done16, bout16, ovf16, zero16;
    logic [15:0] d16;

    typedef struct packed {
        logic [15:0] d;
        logic        bout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t q16[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    chunked_serial_subtractor #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .bin(bin),
        .busy(busy4), .done(done4), .d(d4), .bout(bout4), .ovf(ovf4), .zero(zero4));
    chunked_serial_subtractor #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .bin(bin),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1), .ovf(ovf1), .zero(zero1));
    chunked_serial_subtractor #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a), .b(b), .bin(bin),
        .busy(busy16), .done(done16), .d(d16), .bout(bout16), .ovf(ovf16), .zero(zero16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input exp_t g);
        chk({tag, ".d"},    32'(g.d),    32'(e.d));
        chk({tag, ".bout"}, 32'(g.bout), 32'(e.bout));
        chk({tag, ".ovf"},  32'(g.ovf),  32'(e.ovf));
        chk({tag, ".zero"}, 32'(g.zero), 32'(e.zero));
    endtask

    function automatic exp_t mk(input logic [15:0] md, input logic mb, input logic mo, input logic mz);
        exp_t e;
        e.d = md; e.bout = mb; e.ovf = mo; e.zero = mz;
        return e;
    endfunction

    // Arithmetic reference used for the random sweeps.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        logic [16:0] r;
        exp_t        e;
        r      = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        e.d    = r[15:0];
        e.bout = r[16];
        e.ovf  = (ma[15] != mb[15]) && (r[15] != ma[15]);
        e.zero = (r[15:0] == 16'd0);
        return e;
    endfunction

    // Monitors: pop and compare whenever an instance reports done.
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) chk("c4 unexpected done", 1, 0);
            else cmp("c4", q4.pop_front(), {d4, bout4, ovf4, zero4});
        end
    end
    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) chk("c1 unexpected done", 1, 0);
            else cmp("c1", q1.pop_front(), {d1, bout1, ovf1, zero1});
        end
    end
    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) chk("c16 unexpected done", 1, 0);
            else cmp("c16", q16.pop_front(), {d16, bout16, ovf16, zero16});
        end
    end

    function automatic logic cur_done(input int w);
        case (w)
            1:       return done1;
            16:      return done16;
            default: return done4;
        endcase
    endfunction

    task automatic issue(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                         input exp_t e);
        @(posedge clk); #1;
        a = ia; b = ib; bin = ibin;
        case (w)
            1:       begin start1  = 1'b1; q1.push_back(e);  end
            16:      begin start16 = 1'b1; q16.push_back(e); end
            default: begin start4  = 1'b1; q4.push_back(e);  end
        endcase
        @(posedge clk); #1;
        start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    endtask

    task automatic wait_done(input int w, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (cur_done(w)) return;
            if (n >= 40) begin
                chk("done timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic run(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       input exp_t e);
        int n;
        issue(w, ia, ib, ibin, e);
        wait_done(w, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          seen;
        logic [15:0] ra, rb;
        logic        rbin;

        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #12;
        chk("reset busy", busy4, 0);
        chk("reset done", done4, 0);
        chk("reset d",    d4,    0);
        chk("reset bout", bout4, 0);
        chk("reset ovf",  ovf4,  0);
        chk("reset zero", zero4, 0);
        rst = 1'b0;

        // First scenario with cycle-accurate busy/done timing.
        issue(4, 16'h000F, 16'h0001, 1'b0, mk(16'h000E, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s1 busy during run", busy4, 1);
            chk("s1 done during run", done4, 0);
        end
        @(negedge clk);
        chk("s1 done pulse", done4, 1);
        chk("s1 busy at done", busy4, 0);
        @(negedge clk);
        chk("s1 done drops", done4, 0);

        // Cross-slice borrow, wrap, overflow, zero and boundary vectors.
        run(4, 16'h0100, 16'h0001, 1'b0, mk(16'h00FF, 0, 0, 0));
        run(4, 16'h0002, 16'h0008, 1'b1, mk(16'hFFF9, 1, 0, 0));
        run(4, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 0, 1, 0));
        repeat (3) @(negedge clk);
        chk("result holds in idle", d4, 16'h7FFF);
        run(4, 16'h1234, 16'h1234, 1'b0, mk(16'h0000, 0, 0, 1));
        run(4, 16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1, 0, 1));
        run(4, 16'h8000, 16'h0000, 1'b1, mk(16'h7FFF, 0, 1, 0));

        // start during RUN with different operands is ignored.
        issue(4, 16'h0050, 16'h0030, 1'b0, mk(16'h0020, 0, 0, 0));
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0001; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done(4, n);
        chk("busy-start latency", n, 3);
        repeat (8) @(negedge clk);

        // start held through DONE: back-to-back operations five cycles apart.
        @(posedge clk); #1;
        a = 16'h1000; b = 16'h0001; bin = 1'b0; start4 = 1'b1;
        q4.push_back(mk(16'h0FFF, 0, 0, 0));
        @(posedge clk);
        wait_done(4, n);
        a = 16'h0003; b = 16'h0005;
        q4.push_back(mk(16'hFFFE, 1, 0, 0));
        @(posedge clk); #1;
        start4 = 1'b0;
        wait_done(4, n);
        chk("b2b done spacing", n, 5);

        // Async reset between E2 and E3 discards the in-flight operation.
        @(posedge clk); #1;
        a = 16'h4444; b = 16'h1111; bin = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid reset busy", busy4, 0);
        chk("mid reset done", done4, 0);
        chk("mid reset d",    d4,    0);
        chk("mid reset bout", bout4, 0);
        chk("mid reset ovf",  ovf4,  0);
        chk("mid reset zero", zero4, 0);
        #3 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4) seen++;
        end
        chk("no done after reset", seen, 0);
        run(4, 16'h7FFF, 16'hFFFF, 1'b0, mk(16'h8000, 1, 1, 0));

        // Bit-serial instance.
        issue(1, 16'h000F, 16'h0001, 1'b0, mk(16'h000E, 0, 0, 0));
        wait_done(1, n);
        chk("c1 latency", n, 17);
        run(1, 16'h0000, 16'hFFFF, 1'b1, mk(16'h0000, 1, 0, 1));
        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            run(1, ra, rb, rbin, model(ra, rb, rbin));
        end

        // Single-cycle instance.
        issue(16, 16'h000F, 16'h0001, 1'b0, mk(16'h000E, 0, 0, 0));
        wait_done(16, n);
        chk("c16 latency", n, 2);
        run(16, 16'h8000, 16'h0000, 1'b1, mk(16'h7FFF, 0, 1, 0));
        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
            run(16, ra, rb, rbin, model(ra, rb, rbin));
        end

        repeat (4) @(negedge clk);
        chk("c4 queue drained",  q4.size(),  0);
        chk("c1 queue drained",  q1.size(),  0);
        chk("c16 queue drained", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
